// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - sequential instruction prefetcher with small FIFO and branch redirect
module instr_prefetch_buffer #(
    parameter int                    ADDR_WIDTH = 15,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    output logic                  instr_valid_o,
    output logic [31:0]           instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_ready_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]           mem_rdata_i,
    output logic                  busy_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state_q, state_d;
    logic                    fetch_ok;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   infl_addr_q;

    logic [31:0]             data_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   addr_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wptr_q, rptr_q;
    logic [CNT_W-1:0]        count_q;

    logic [CNT_W:0]          occupancy;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic [ADDR_WIDTH-1:0]   target;
    logic [ADDR_WIDTH-1:0]   fetch_addr;

    always_comb begin
        state_d  = state_q;
        fetch_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_en_i) begin
                    state_d  = RUN;
                    fetch_ok = 1'b1;
                end
            end
            RUN: begin
                if (!fetch_en_i) begin
                    state_d = IDLE;
                end else begin
                    fetch_ok = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit counts buffered plus in-flight words; a same-cycle pop is deliberately not counted.
    assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue      = rst_n && fetch_ok && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign target     = branch_addr_i & WORD_MASK;
    assign fetch_addr = branch_i ? target : pc_q;

    assign mem_en_o   = issue;
    assign mem_addr_o = fetch_addr;
    assign busy_o     = inflight_q;

    assign push = inflight_q && !branch_i;
    assign pop  = instr_valid_o && instr_ready_i && !branch_i;

    assign instr_valid_o = (count_q != '0);
    assign instr_rdata_o = data_q[rptr_q];
    assign instr_addr_o  = addr_q[rptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= BOOT_ADDR;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (issue) begin
                infl_addr_q <= fetch_addr;
            end
            if (branch_i) begin
                pc_q <= issue ? (target + WORD_STEP) : target;
            end else if (issue) begin
                pc_q <= pc_q + WORD_STEP;
            end
        end
    end

    // A branch flushes the queue and drops the response arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (branch_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                data_q[wptr_q] <= mem_rdata_i;
                addr_q[wptr_q] <= infl_addr_q;
                wptr_q         <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb/tb_instr_prefetch_buffer.sv - scoreboard bench for instr_prefetch_buffer
module tb_instr_prefetch_buffer;

    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_en_i;
    logic          branch_i;
    logic [AW-1:0] branch_addr_i;
    logic          instr_valid_o;
    logic [31:0]   instr_rdata_o;
    logic [AW-1:0] instr_addr_o;
    logic          instr_ready_i;
    logic          mem_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_rdata_i = 32'hDEAD_BEEF;
    logic          busy_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [AW-1:0] exp_q [$];

    instr_prefetch_buffer #(
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (4),
        .BOOT_ADDR  ('0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .instr_valid_o (instr_valid_o),
        .instr_rdata_o (instr_rdata_o),
        .instr_addr_o  (instr_addr_o),
        .instr_ready_i (instr_ready_i),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [AW-1:0] a);
        return 32'(a) ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    // Memory responder: sample the request before the edge, return data just after it.
    initial begin
        logic          r_en;
        logic [AW-1:0] r_addr;
        forever begin
            @(negedge clk);
            #3;
            r_en   = mem_en_o;
            r_addr = mem_addr_o;
            @(posedge clk);
            #1;
            mem_rdata_i = r_en ? word_of(r_addr) : 32'hDEAD_BEEF;
        end
    end

    // Monitor: every accepted instruction is compared against the next expected entry.
    initial begin
        logic [AW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && instr_valid_o && instr_ready_i && !branch_i) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_delivery: got addr 0x%0h expected none", instr_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_addr", 32'(instr_addr_o), 32'(e));
                    check("deliver_data", instr_rdata_o, word_of(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},    32'(instr_valid_o), 32'd0);
        check({tag, "_rdata"},    instr_rdata_o,      32'd0);
        check({tag, "_addr"},     32'(instr_addr_o),  32'd0);
        check({tag, "_mem_en"},   32'(mem_en_o),      32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr_o),    32'd0);
        check({tag, "_busy"},     32'(busy_o),        32'd0);
    endtask

    initial begin
        rst_n = 1'b0; fetch_en_i = 1'b0; branch_i = 1'b0;
        branch_addr_i = '0; instr_ready_i = 1'b0;

        for (int a = 'h0;    a <= 'h10;   a += 4) exp_q.push_back(AW'(a));
        for (int a = 'h4000; a <= 'h400C; a += 4) exp_q.push_back(AW'(a));
        exp_q.push_back(15'h7FFC);
        for (int a = 'h0;    a <= 'h8;    a += 4) exp_q.push_back(AW'(a));
        for (int a = 'h3FFC; a <= 'h4010; a += 4) exp_q.push_back(AW'(a));
        for (int a = 'h0;    a <= 'h1C;   a += 4) exp_q.push_back(AW'(a));

        repeat (2) next_cycle();
        #1;
        check_reset_outputs("reset");
        next_cycle();
        rst_n = 1'b1;

        // Fill with ready low: four requests, then credit exhausted.
        for (int c = 0; c < 7; c++) begin
            next_cycle();
            fetch_en_i = 1'b1; instr_ready_i = 1'b0;
            #1;
            check("fill_mem_en", 32'(mem_en_o), (c < 4) ? 32'd1 : 32'd0);
            if (c < 4) check("fill_mem_addr", 32'(mem_addr_o), 32'(4 * c));
            check("fill_valid", 32'(instr_valid_o), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) check("fill_head_addr", 32'(instr_addr_o), 32'h0);
            if (c == 1) check("fill_busy", 32'(busy_o), 32'd1);
            if (c == 5) check("fill_busy_idle", 32'(busy_o), 32'd0);
        end

        // Cycle 7: ready rises, the pop gives no credit this cycle.
        next_cycle();
        instr_ready_i = 1'b1;
        #1;
        check("resume_mem_en_first", 32'(mem_en_o), 32'd0);
        for (int c = 8; c < 12; c++) begin
            next_cycle();
            #1;
            check("stream_mem_en", 32'(mem_en_o), 32'd1);
            check("stream_mem_addr", 32'(mem_addr_o), 32'(4 * (c - 4)));
            check("stream_valid", 32'(instr_valid_o), 32'd1);
        end

        // Cycle 12: branch to 0x4003.
        next_cycle();
        branch_i = 1'b1; branch_addr_i = 15'h4003;
        #1;
        check("br_mem_en", 32'(mem_en_o), 32'd1);
        check("br_mem_addr", 32'(mem_addr_o), 32'h4000);
        next_cycle();
        branch_i = 1'b0;
        #1;
        check("br_valid_t1", 32'(instr_valid_o), 32'd0);
        check("br_mem_addr_t1", 32'(mem_addr_o), 32'h4004);
        next_cycle();
        #1;
        check("br_valid_t2", 32'(instr_valid_o), 32'd1);
        check("br_head_t2", 32'(instr_addr_o), 32'h4000);
        repeat (3) next_cycle();

        // Cycle 18: branch to the top of the space, next request wraps to 0.
        next_cycle();
        branch_i = 1'b1; branch_addr_i = 15'h7FFC;
        #1;
        check("wrap_br_addr", 32'(mem_addr_o), 32'h7FFC);
        next_cycle();
        branch_i = 1'b0;
        #1;
        check("wrap_mem_en", 32'(mem_en_o), 32'd1);
        check("wrap_mem_addr", 32'(mem_addr_o), 32'h0);
        repeat (4) next_cycle();

        // Cycle 24: branch to the last ROM word, fetching crosses into RAM.
        next_cycle();
        branch_i = 1'b1; branch_addr_i = 15'h3FFC;
        #1;
        check("cross_br_addr", 32'(mem_addr_o), 32'h3FFC);
        next_cycle();
        branch_i = 1'b0;
        #1;
        check("cross_mem_addr", 32'(mem_addr_o), 32'h4000);
        repeat (4) next_cycle();

        // Cycle 30: drop fetch enable with a request in flight.
        next_cycle();
        fetch_en_i = 1'b0;
        #1;
        check("stop_mem_en", 32'(mem_en_o), 32'd0);
        check("stop_busy", 32'(busy_o), 32'd1);
        next_cycle();
        #1;
        check("stop_busy_next", 32'(busy_o), 32'd0);
        check("stop_last_head", 32'(instr_addr_o), 32'h4010);
        next_cycle();
        #1;
        check("stop_drained", 32'(instr_valid_o), 32'd0);

        // Cycles 33..36: refill three entries plus one in flight, then reset.
        for (int c = 33; c < 37; c++) begin
            next_cycle();
            fetch_en_i = 1'b1; instr_ready_i = 1'b0;
        end
        next_cycle();
        #1;
        check("prerst_valid", 32'(instr_valid_o), 32'd1);
        check("prerst_busy", 32'(busy_o), 32'd1);
        check("prerst_mem_en", 32'(mem_en_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        next_cycle();
        next_cycle();
        rst_n = 1'b1; instr_ready_i = 1'b1;
        #1;
        check("restart_mem_en", 32'(mem_en_o), 32'd1);
        check("restart_mem_addr", 32'(mem_addr_o), 32'h0);
        repeat (7) next_cycle();
        next_cycle();
        fetch_en_i = 1'b0;

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            next_cycle();
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) next_cycle();
        #1;
        check("final_valid", 32'(instr_valid_o), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
